// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and width helpers for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Shared cycle counter must reach the largest of the three cycle limits.
    function automatic int cnt_width(input int a, input int b, input int c);
        return $clog2(max3(a, b, c)) + 1;
    endfunction

    function automatic int retry_width(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_bit.sv
// Multi-stage flop synchronizer for a single asynchronous bit, async-reset to 0.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, waits for and qualifies lock, then releases sys_rst.
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 7,
    parameter int SYNC_STAGES    = 2,
    localparam int RTY_W         = retry_width(MAX_RETRIES)
) (
    input  logic             i_refclk,
    input  logic             i_rst,
    input  logic             i_pll_locked,
    input  logic             i_fail_clr,
    output logic             o_pll_rst,
    output logic             o_sys_rst,
    output logic             o_ready,
    output logic             o_fail,
    output logic [RTY_W-1:0] o_retry_cnt,
    output logic [7:0]       o_loss_cnt
);

    localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX      = RTY_W'(MAX_RETRIES);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [RTY_W-1:0] r_retry_cnt;
    logic [7:0]       r_loss_cnt;
    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_ready;
    logic             r_fail;
    logic             w_locked_s;
    logic             w_retry_inc;
    logic             w_retry_clr;
    logic             w_loss_inc;
    logic             w_pll_rst_next;
    logic             w_sys_rst_next;
    logic             w_ready_next;
    logic             w_fail_next;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk (i_refclk),
        .i_rst (i_rst),
        .i_d   (i_pll_locked),
        .o_q   (w_locked_s)
    );

    // Outputs are flopped from the next-state decode so they track r_state exactly, glitch-free.
    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= RESET_PLL;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pll_rst <= w_pll_rst_next;
            r_sys_rst <= w_sys_rst_next;
            r_ready   <= w_ready_next;
            r_fail    <= w_fail_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_retry_inc  = 1'b0;
        w_retry_clr  = 1'b0;
        w_loss_inc   = 1'b0;
        case (r_state)
            RESET_PLL: begin
                if (r_cnt == RST_LAST) begin
                    w_state_next = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // Lock arriving in the timeout cycle takes precedence over a retry.
                if (w_locked_s) begin
                    w_state_next = STABLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    if (r_retry_cnt == RTY_MAX) begin
                        w_state_next = FAIL;
                    end else begin
                        w_state_next = RESET_PLL;
                        w_retry_inc  = 1'b1;
                    end
                end
            end
            STABLE: begin
                if (!w_locked_s) begin
                    w_state_next = WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_next = RUN;
                    w_retry_clr  = 1'b1;
                end
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_state_next = RESET_PLL;
                    w_loss_inc   = 1'b1;
                end
            end
            FAIL: begin
                if (i_fail_clr) begin
                    w_state_next = RESET_PLL;
                    w_retry_clr  = 1'b1;
                end
            end
            default: begin
                w_state_next = RESET_PLL;
            end
        endcase
    end

    always_comb begin
        w_pll_rst_next = (w_state_next == RESET_PLL);
        w_sys_rst_next = (w_state_next != RUN);
        w_ready_next   = (w_state_next == RUN);
        w_fail_next    = (w_state_next == FAIL);
    end

    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_retry_cnt <= '0;
            r_loss_cnt  <= '0;
        end else begin
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == RESET_PLL || r_state == WAIT_LOCK || r_state == STABLE) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_retry_clr) begin
                r_retry_cnt <= '0;
            end else if (w_retry_inc) begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
            end

            if (w_loss_inc && r_loss_cnt != 8'hFF) begin
                r_loss_cnt <= r_loss_cnt + 8'd1;
            end
        end
    end

    assign o_pll_rst   = r_pll_rst;
    assign o_sys_rst   = r_sys_rst;
    assign o_ready     = r_ready;
    assign o_fail      = r_fail;
    assign o_retry_cnt = r_retry_cnt;
    assign o_loss_cnt  = r_loss_cnt;

endmodule
